// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states, the data word and the
// memory arbiter FSM encoding.
package cpu_types_pkg;

    // Width of a CPU data/address word
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Handshake state reported by the RAM for the access currently driven
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory arbiter ownership of the single RAM port
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

    // True when the RAM completes the access driven this cycle
    function automatic logic ram_done(input ramstate_t rs);
        return rs == ACCESS;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Port bundle between the instruction/data caches, the arbiter and the RAM.
interface mem_arbiter_if
    import cpu_types_pkg::*;
(
    input logic CLK,
    input logic RST
);

    // icache side
    logic        iREN;
    word_t       iaddr;
    logic        iwait;
    word_t       iload;

    // dcache side
    logic        dREN;
    logic        dWEN;
    word_t       daddr;
    word_t       dstore;
    logic        dwait;
    word_t       dload;

    // RAM side
    logic        ramREN;
    logic        ramWEN;
    word_t       ramaddr;
    word_t       ramstore;
    word_t       ramload;
    logic [1:0]  ramstate;
    logic        ramerr;

    // View seen by the arbiter itself
    modport arb (
        input  CLK, RST,
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

    // View seen by caches/RAM models driving the arbiter
    modport tb (
        input  CLK, RST,
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore, ramerr
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between icache and dcache. dcache has priority,
// but an icache request that has watched STARVE_LIMIT consecutive dcache
// completions gets the next grant. A grant lasts until the RAM reports
// ACCESS or the owner withdraws; one IDLE cycle separates grants.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 2
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,

    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,

    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ramerr
);

    // Counter must be at least one bit even when STARVE_LIMIT is 0
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_next;

    ramstate_t        rstate;
    logic             dreq;
    logic             access;
    logic             i_done;
    logic             d_done;
    logic             i_starved;

    assign rstate    = ramstate_t'(ramstate);
    assign dreq      = dREN | dWEN;
    assign access    = ram_done(rstate);
    assign i_starved = iREN && (starve_cnt == CNT_MAX);

    // Read data is passed straight through; it is meaningful only in the
    // owner's ACCESS cycle.
    assign iload = ramload;
    assign dload = ramload;

    // Next-state and all outputs, decoded from the current grant and inputs
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case can leave one unassigned and infer a latch.
        state_next = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        ramerr     = 1'b0;
        iwait      = iREN;
        dwait      = dreq;
        i_done     = 1'b0;
        d_done     = 1'b0;

        unique case (state)
            IDLE: begin
                if (dreq && !i_starved) begin
                    state_next = DGRANT;
                end else if (iREN) begin
                    state_next = IGRANT;
                end
            end

            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                ramerr  = (rstate == ERROR);
                if (!iREN) begin
                    // Withdrawn request: abandon without completion
                    state_next = IDLE;
                end else if (access) begin
                    iwait      = 1'b0;
                    i_done     = 1'b1;
                    state_next = IDLE;
                end
            end

            DGRANT: begin
                // Write wins when both request lines are raised
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                ramerr   = (rstate == ERROR);
                if (!dreq) begin
                    state_next = IDLE;
                end else if (access) begin
                    dwait      = 1'b0;
                    d_done     = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Starvation counter: counts dcache completions the icache sat through
    always_comb begin
        starve_next = starve_cnt;
        if (!iREN || i_done) begin
            starve_next = '0;
        end else if (d_done && (starve_cnt != CNT_MAX)) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    // State and counter registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Stimulus pushes the expected completion
// of each transfer into a scoreboard; a monitor pops and compares whenever
// an owner's wait drops while it is requesting.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic        is_d;
        logic [31:0] addr;
        logic        wen;
        logic        ren;
        logic [31:0] store;
        logic [31:0] load;
    } txn_t;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;
    txn_t sb[$];

    mem_arbiter_if bus (.CLK(clk), .RST(rst));

    mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .CLK      (clk),
        .RST      (rst),
        .iREN     (bus.iREN),
        .iaddr    (bus.iaddr),
        .iwait    (bus.iwait),
        .iload    (bus.iload),
        .dREN     (bus.dREN),
        .dWEN     (bus.dWEN),
        .daddr    (bus.daddr),
        .dstore   (bus.dstore),
        .dwait    (bus.dwait),
        .dload    (bus.dload),
        .ramREN   (bus.ramREN),
        .ramWEN   (bus.ramWEN),
        .ramaddr  (bus.ramaddr),
        .ramstore (bus.ramstore),
        .ramload  (bus.ramload),
        .ramstate (bus.ramstate),
        .ramerr   (bus.ramerr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void expect_i(input logic [31:0] addr, input logic [31:0] load);
        sb.push_back('{is_d: 1'b0, addr: addr, wen: 1'b0, ren: 1'b1, store: 32'h0, load: load});
    endfunction

    function automatic void expect_d(input logic [31:0] addr, input logic wen, input logic ren,
                                     input logic [31:0] store, input logic [31:0] load);
        sb.push_back('{is_d: 1'b1, addr: addr, wen: wen, ren: ren,
                       store: wen ? store : 32'h0, load: load});
    endfunction

    // Monitor: a completion is an owner's wait low while it requests
    always @(negedge clk) begin
        if (!rst) begin
            logic i_cmp;
            logic d_cmp;
            txn_t act;
            txn_t exp;
            i_cmp = bus.iREN && !bus.iwait;
            d_cmp = (bus.dREN || bus.dWEN) && !bus.dwait;
            if (i_cmp || d_cmp) begin
                act.is_d  = d_cmp;
                act.addr  = bus.ramaddr;
                act.wen   = bus.ramWEN;
                act.ren   = bus.ramREN;
                act.store = bus.ramWEN ? bus.ramstore : 32'h0;
                act.load  = d_cmp ? bus.dload : bus.iload;
                if (i_cmp && d_cmp) begin
                    check("both_owners_complete", 128'(1), 128'(0));
                end else if (sb.size() == 0) begin
                    check("unexpected_completion", 128'(act), 128'(0));
                end else begin
                    exp = sb.pop_front();
                    check("completion", 128'(act), 128'(exp));
                end
            end
        end
    end

    // Runs one grant from the IDLE cycle: n_err ERROR cycles, then n_busy
    // BUSY cycles, then ACCESS. Returns grant length, ramerr count and
    // whether ramaddr stayed constant.
    task automatic do_access(input int n_busy, input int n_err,
                             output int grant_cycles, output int err_cycles,
                             output logic addr_stable);
        logic [31:0] first_addr;
        grant_cycles = 0;
        err_cycles   = 0;
        addr_stable  = 1'b1;
        first_addr   = '0;
        bus.ramstate = FREE;
        @(posedge clk);
        for (int k = 0; k <= n_busy + n_err; k++) begin
            #1;
            if (k < n_err)               bus.ramstate = ERROR;
            else if (k < n_err + n_busy) bus.ramstate = BUSY;
            else                         bus.ramstate = ACCESS;
            @(negedge clk);
            if (bus.ramREN || bus.ramWEN) grant_cycles++;
            if (bus.ramerr)               err_cycles++;
            if (k == 0)                   first_addr = bus.ramaddr;
            else if (bus.ramaddr !== first_addr) addr_stable = 1'b0;
            @(posedge clk);
        end
        #1;
        bus.ramstate = FREE;
    endtask

    task automatic drop_all();
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   gc;
        int   ec;
        logic st;

        rst          = 1'b1;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;

        // Reset state
        @(negedge clk);
        check("rst_ramREN",   128'(bus.ramREN),   128'(0));
        check("rst_ramWEN",   128'(bus.ramWEN),   128'(0));
        check("rst_ramaddr",  128'(bus.ramaddr),  128'(0));
        check("rst_ramstore", 128'(bus.ramstore), 128'(0));
        check("rst_ramerr",   128'(bus.ramerr),   128'(0));
        check("rst_iwait",    128'(bus.iwait),    128'(0));
        bus.dREN = 1'b1;
        bus.iREN = 1'b1;
        #1;
        check("rst_dwait_follows", 128'(bus.dwait),  128'(1));
        check("rst_iwait_follows", 128'(bus.iwait),  128'(1));
        check("rst_no_grant",      128'(bus.ramREN), 128'(0));
        drop_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle();

        // icache read, two BUSY cycles then ACCESS
        bus.iREN    = 1'b1;
        bus.iaddr   = 32'h40;
        bus.ramload = 32'hDEADBEEF;
        expect_i(32'h40, 32'hDEADBEEF);
        do_access(2, 0, gc, ec, st);
        check("i_grant_len", 128'(gc), 128'(3));
        drop_all();
        idle_cycle();

        // Simultaneous icache read and dcache write: D first, bubble, then I
        bus.iREN    = 1'b1;
        bus.iaddr   = 32'h80;
        bus.dWEN    = 1'b1;
        bus.daddr   = 32'h100;
        bus.dstore  = 32'h12345678;
        bus.ramload = 32'h0000AAAA;
        expect_d(32'h100, 1'b1, 1'b0, 32'h12345678, 32'h0000AAAA);
        expect_i(32'h80, 32'h0000AAAA);
        do_access(0, 0, gc, ec, st);
        bus.dWEN = 1'b0;
        @(negedge clk);
        check("bubble_no_drive", 128'({bus.ramREN, bus.ramWEN}), 128'(0));
        check("bubble_iwait",    128'(bus.iwait), 128'(1));
        do_access(0, 0, gc, ec, st);
        drop_all();
        idle_cycle();

        // Starvation limit: D, D, I, D, D, I
        bus.iREN    = 1'b1;
        bus.iaddr   = 32'h300;
        bus.dREN    = 1'b1;
        bus.daddr   = 32'h200;
        bus.ramload = 32'h11112222;
        expect_d(32'h200, 1'b0, 1'b1, 32'h0, 32'h11112222);
        expect_d(32'h200, 1'b0, 1'b1, 32'h0, 32'h11112222);
        expect_i(32'h300, 32'h11112222);
        expect_d(32'h200, 1'b0, 1'b1, 32'h0, 32'h11112222);
        expect_d(32'h200, 1'b0, 1'b1, 32'h0, 32'h11112222);
        expect_i(32'h300, 32'h11112222);
        for (int g = 0; g < 6; g++) begin
            do_access(0, 0, gc, ec, st);
        end
        drop_all();
        idle_cycle();

        // dcache read with two ERROR cycles before ACCESS
        bus.dREN    = 1'b1;
        bus.daddr   = 32'h400;
        bus.ramload = 32'hCAFEF00D;
        expect_d(32'h400, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D);
        do_access(0, 2, gc, ec, st);
        check("err_ramerr_cycles", 128'(ec), 128'(2));
        check("err_grant_len",     128'(gc), 128'(3));
        check("err_addr_stable",   128'(st), 128'(1));
        drop_all();
        idle_cycle();

        // Reset in the middle of a dcache write grant
        bus.dWEN     = 1'b1;
        bus.daddr    = 32'h500;
        bus.dstore   = 32'h000055AA;
        bus.ramstate = BUSY;
        @(posedge clk);
        @(negedge clk);
        check("midrst_granted", 128'(bus.ramWEN), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ramWEN",   128'(bus.ramWEN),   128'(0));
        check("midrst_ramREN",   128'(bus.ramREN),   128'(0));
        check("midrst_ramaddr",  128'(bus.ramaddr),  128'(0));
        check("midrst_ramstore", 128'(bus.ramstore), 128'(0));
        check("midrst_dwait",    128'(bus.dwait),    128'(1));
        bus.ramstate = ACCESS;
        @(negedge clk);
        check("midrst_held_idle", 128'({bus.ramREN, bus.ramWEN, bus.dwait}), 128'(3'b001));
        drop_all();
        bus.ramstate = FREE;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle();

        // Read and write raised together: write wins
        bus.dREN    = 1'b1;
        bus.dWEN    = 1'b1;
        bus.daddr   = 32'h600;
        bus.dstore  = 32'h0BADF00D;
        bus.ramload = 32'h77778888;
        expect_d(32'h600, 1'b1, 1'b0, 32'h0BADF00D, 32'h77778888);
        do_access(1, 0, gc, ec, st);
        check("rw_grant_len", 128'(gc), 128'(2));
        drop_all();
        idle_cycle();

        // icache withdraws mid-grant: back to IDLE, no completion
        bus.iREN     = 1'b1;
        bus.iaddr    = 32'h700;
        bus.ramstate = BUSY;
        @(posedge clk);
        @(negedge clk);
        check("drop_granted", 128'({bus.ramREN, bus.ramaddr}), {95'd0, 1'b1, 32'h700});
        @(posedge clk);
        #1;
        bus.iREN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("drop_back_idle", 128'({bus.ramREN, bus.ramWEN}), 128'(0));
        bus.ramstate = FREE;
        idle_cycle();
        idle_cycle();

        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
